// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_if
//  Description : Bus bundle for the register-file write-port arbiter:
//                pipeline writeback, MDU and debug request channels plus the
//                registered write-port outputs and the stall request.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
  // Pipeline writeback (no backpressure)
  logic        pipe_do_wb_i;
  logic [3:0]  pipe_wb_reg_i;
  logic [31:0] pipe_wb_val_i;
  // MDU request channel
  logic        mdu_valid_i;
  logic [3:0]  mdu_reg_i;
  logic [31:0] mdu_val_i;
  logic        mdu_ready_o;
  // Debug request channel
  logic        dbg_valid_i;
  logic [3:0]  dbg_reg_i;
  logic [31:0] dbg_val_i;
  logic        dbg_ready_o;
  // Front-end stall and register-file write port
  logic        stall_o;
  logic        do_wb_o;
  logic [3:0]  wb_reg_o;
  logic [31:0] wb_val_o;
  logic [1:0]  wb_src_o;

  // Arbiter side
  modport slave (
    input  pipe_do_wb_i, pipe_wb_reg_i, pipe_wb_val_i,
    input  mdu_valid_i, mdu_reg_i, mdu_val_i,
    output mdu_ready_o,
    input  dbg_valid_i, dbg_reg_i, dbg_val_i,
    output dbg_ready_o,
    output stall_o, do_wb_o, wb_reg_o, wb_val_o, wb_src_o
  );

  // Requester / consumer side
  modport master (
    output pipe_do_wb_i, pipe_wb_reg_i, pipe_wb_val_i,
    output mdu_valid_i, mdu_reg_i, mdu_val_i,
    input  mdu_ready_o,
    output dbg_valid_i, dbg_reg_i, dbg_val_i,
    input  dbg_ready_o,
    input  stall_o, do_wb_o, wb_reg_o, wb_val_o, wb_src_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the single register-file write port among pipeline
//                writeback (absolute priority), the MDU and the debug port
//                (round-robin between the two). Long-waiting secondary
//                requests raise a registered stall toward the front end.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  wire                 clk_i,
  input  wire                 rst_i,
  wb_port_arbiter_if.slave    bus
);

  localparam int              c_CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0] c_LIM = c_CW'(STARVE_LIMIT);
  localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

  localparam logic [1:0] c_SRC_NONE = 2'd0;
  localparam logic [1:0] c_SRC_PIPE = 2'd1;
  localparam logic [1:0] c_SRC_MDU  = 2'd2;
  localparam logic [1:0] c_SRC_DBG  = 2'd3;

  logic            r_rr_ptr;   // 0 favours MDU, 1 favours debug
  logic [c_CW-1:0] r_mdu_cnt;
  logic [c_CW-1:0] r_dbg_cnt;
  logic            r_stall;
  logic            r_do_wb;
  logic [3:0]      r_wb_reg;
  logic [31:0]     r_wb_val;
  logic [1:0]      r_wb_src;

  logic w_mdu_gnt;
  logic w_dbg_gnt;
  logic w_both;

  // Grant decode: pipeline first, then the single valid secondary, else rr_ptr.
  // Nothing is accepted while reset is held so in-flight requests are re-presented.
  always_comb begin
    w_both    = bus.mdu_valid_i && bus.dbg_valid_i;
    w_mdu_gnt = !rst_i && !bus.pipe_do_wb_i && bus.mdu_valid_i &&
                (!bus.dbg_valid_i || !r_rr_ptr);
    w_dbg_gnt = !rst_i && !bus.pipe_do_wb_i && bus.dbg_valid_i &&
                (!bus.mdu_valid_i || r_rr_ptr);
  end

  assign bus.mdu_ready_o = w_mdu_gnt;
  assign bus.dbg_ready_o = w_dbg_gnt;

  // Round-robin pointer moves to the loser only when both secondaries competed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= 1'b0;
    end else if ((w_mdu_gnt || w_dbg_gnt) && w_both) begin
      r_rr_ptr <= w_mdu_gnt;
    end
  end

  // Per-source wait counters: count unaccepted cycles, saturate, clear otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mdu_cnt <= '0;
      r_dbg_cnt <= '0;
    end else begin
      if (bus.mdu_valid_i && !w_mdu_gnt)
        r_mdu_cnt <= (r_mdu_cnt == c_LIM) ? c_LIM : r_mdu_cnt + c_ONE;
      else
        r_mdu_cnt <= '0;
      if (bus.dbg_valid_i && !w_dbg_gnt)
        r_dbg_cnt <= (r_dbg_cnt == c_LIM) ? c_LIM : r_dbg_cnt + c_ONE;
      else
        r_dbg_cnt <= '0;
    end
  end

  // Stall follows the current counter values, so it trails a transfer by a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall <= 1'b0;
    end else begin
      r_stall <= (r_mdu_cnt == c_LIM) || (r_dbg_cnt == c_LIM);
    end
  end

  // Write-port register: winner's reg/val/tag, reg/val hold when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_do_wb  <= 1'b0;
      r_wb_reg <= '0;
      r_wb_val <= '0;
      r_wb_src <= c_SRC_NONE;
    end else if (bus.pipe_do_wb_i) begin
      r_do_wb  <= 1'b1;
      r_wb_reg <= bus.pipe_wb_reg_i;
      r_wb_val <= bus.pipe_wb_val_i;
      r_wb_src <= c_SRC_PIPE;
    end else if (w_mdu_gnt) begin
      r_do_wb  <= 1'b1;
      r_wb_reg <= bus.mdu_reg_i;
      r_wb_val <= bus.mdu_val_i;
      r_wb_src <= c_SRC_MDU;
    end else if (w_dbg_gnt) begin
      r_do_wb  <= 1'b1;
      r_wb_reg <= bus.dbg_reg_i;
      r_wb_val <= bus.dbg_val_i;
      r_wb_src <= c_SRC_DBG;
    end else begin
      r_do_wb  <= 1'b0;
      r_wb_src <= c_SRC_NONE;
    end
  end

  assign bus.stall_o  = r_stall;
  assign bus.do_wb_o  = r_do_wb;
  assign bus.wb_reg_o = r_wb_reg;
  assign bus.wb_val_o = r_wb_val;
  assign bus.wb_src_o = r_wb_src;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Directed self-checking bench for wb_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int c_LIM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_port_arbiter_if tb_if ();

  wb_port_arbiter #(.STARVE_LIMIT(c_LIM)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (tb_if)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tb_if.pipe_do_wb_i  = 1'b0;
    tb_if.pipe_wb_reg_i = 4'd0;
    tb_if.pipe_wb_val_i = 32'd0;
    tb_if.mdu_valid_i   = 1'b0;
    tb_if.mdu_reg_i     = 4'd0;
    tb_if.mdu_val_i     = 32'd0;
    tb_if.dbg_valid_i   = 1'b0;
    tb_if.dbg_reg_i     = 4'd0;
    tb_if.dbg_val_i     = 32'd0;
  endtask

  task automatic test_reset();
    tb_if.pipe_do_wb_i = 1'b1; tb_if.pipe_wb_reg_i = 4'd9; tb_if.pipe_wb_val_i = 32'h99;
    tb_if.mdu_valid_i  = 1'b1; tb_if.mdu_reg_i = 4'd4; tb_if.mdu_val_i = 32'h44;
    tb_if.dbg_valid_i  = 1'b1; tb_if.dbg_reg_i = 4'd6; tb_if.dbg_val_i = 32'h66;
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (tb_if.do_wb_o !== 1'b0) begin n_fail++; $display("FAIL rst_do_wb got=%b exp=0", tb_if.do_wb_o); end
    n_checks++; if (tb_if.wb_reg_o !== 4'd0) begin n_fail++; $display("FAIL rst_wb_reg got=%0d exp=0", tb_if.wb_reg_o); end
    n_checks++; if (tb_if.wb_val_o !== 32'd0) begin n_fail++; $display("FAIL rst_wb_val got=%h exp=0", tb_if.wb_val_o); end
    n_checks++; if (tb_if.wb_src_o !== 2'd0) begin n_fail++; $display("FAIL rst_wb_src got=%0d exp=0", tb_if.wb_src_o); end
    n_checks++; if (tb_if.stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", tb_if.stall_o); end
    tb_if.pipe_do_wb_i = 1'b0;
    #1;
    n_checks++; if (tb_if.mdu_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mdu_ready got=%b exp=0", tb_if.mdu_ready_o); end
    n_checks++; if (tb_if.dbg_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_dbg_ready got=%b exp=0", tb_if.dbg_ready_o); end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pipe_priority();
    tb_if.pipe_do_wb_i = 1'b1; tb_if.pipe_wb_reg_i = 4'd3; tb_if.pipe_wb_val_i = 32'h11;
    tb_if.mdu_valid_i  = 1'b1; tb_if.mdu_reg_i = 4'd5; tb_if.mdu_val_i = 32'h22;
    #1;
    n_checks++; if (tb_if.mdu_ready_o !== 1'b0) begin n_fail++; $display("FAIL pri_mdu_blocked got=%b exp=0", tb_if.mdu_ready_o); end
    tick();
    tb_if.pipe_do_wb_i = 1'b0;
    #1;
    n_checks++; if ({tb_if.do_wb_o, tb_if.wb_reg_o, tb_if.wb_val_o, tb_if.wb_src_o} !== {1'b1, 4'd3, 32'h11, 2'd1})
      begin n_fail++; $display("FAIL pri_pipe_write got=%b/%0d/%h/%0d exp=1/3/11/1", tb_if.do_wb_o, tb_if.wb_reg_o, tb_if.wb_val_o, tb_if.wb_src_o); end
    n_checks++; if (tb_if.mdu_ready_o !== 1'b1) begin n_fail++; $display("FAIL pri_mdu_accept got=%b exp=1", tb_if.mdu_ready_o); end
    tick();
    tb_if.mdu_valid_i = 1'b0;
    n_checks++; if ({tb_if.do_wb_o, tb_if.wb_reg_o, tb_if.wb_val_o, tb_if.wb_src_o} !== {1'b1, 4'd5, 32'h22, 2'd2})
      begin n_fail++; $display("FAIL pri_mdu_write got=%b/%0d/%h/%0d exp=1/5/22/2", tb_if.do_wb_o, tb_if.wb_reg_o, tb_if.wb_val_o, tb_if.wb_src_o); end
    tick();
    n_checks++; if ({tb_if.do_wb_o, tb_if.wb_reg_o, tb_if.wb_val_o, tb_if.wb_src_o} !== {1'b0, 4'd5, 32'h22, 2'd0})
      begin n_fail++; $display("FAIL pri_idle_hold got=%b/%0d/%h/%0d exp=0/5/22/0", tb_if.do_wb_o, tb_if.wb_reg_o, tb_if.wb_val_o, tb_if.wb_src_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_src;
    tb_if.mdu_valid_i = 1'b1; tb_if.mdu_reg_i = 4'd1; tb_if.mdu_val_i = 32'hA;
    tb_if.dbg_valid_i = 1'b1; tb_if.dbg_reg_i = 4'd2; tb_if.dbg_val_i = 32'hB;
    for (int i = 0; i < 4; i++) begin
      exp_src = (i % 2 == 0) ? 2'd2 : 2'd3;
      #1;
      n_checks++; if ({tb_if.mdu_ready_o, tb_if.dbg_ready_o} !== {exp_src == 2'd2, exp_src == 2'd3})
        begin n_fail++; $display("FAIL rr_ready[%0d] got=%b%b exp_src=%0d", i, tb_if.mdu_ready_o, tb_if.dbg_ready_o, exp_src); end
      tick();
      n_checks++; if ({tb_if.do_wb_o, tb_if.wb_src_o, tb_if.wb_reg_o} !== {1'b1, exp_src, (exp_src == 2'd2) ? 4'd1 : 4'd2})
        begin n_fail++; $display("FAIL rr_write[%0d] got=%b/%0d/%0d exp_src=%0d", i, tb_if.do_wb_o, tb_if.wb_src_o, tb_if.wb_reg_o, exp_src); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starve();
    tb_if.pipe_do_wb_i = 1'b1; tb_if.pipe_wb_reg_i = 4'd8; tb_if.pipe_wb_val_i = 32'h80;
    tb_if.mdu_valid_i  = 1'b1; tb_if.mdu_reg_i = 4'd12; tb_if.mdu_val_i = 32'hC0FFEE;
    for (int k = 1; k <= c_LIM + 1; k++) begin
      tick();
      n_checks++; if (tb_if.stall_o !== (k == c_LIM + 1))
        begin n_fail++; $display("FAIL starve_stall[%0d] got=%b exp=%b", k, tb_if.stall_o, (k == c_LIM + 1)); end
    end
    n_checks++; if (tb_if.wb_src_o !== 2'd1) begin n_fail++; $display("FAIL starve_pipe_src got=%0d exp=1", tb_if.wb_src_o); end
    tb_if.pipe_do_wb_i = 1'b0;
    #1;
    n_checks++; if (tb_if.mdu_ready_o !== 1'b1) begin n_fail++; $display("FAIL starve_accept got=%b exp=1", tb_if.mdu_ready_o); end
    tick();
    tb_if.mdu_valid_i = 1'b0;
    n_checks++; if ({tb_if.do_wb_o, tb_if.wb_src_o, tb_if.wb_val_o} !== {1'b1, 2'd2, 32'hC0FFEE})
      begin n_fail++; $display("FAIL starve_mdu_write got=%b/%0d/%h exp=1/2/c0ffee", tb_if.do_wb_o, tb_if.wb_src_o, tb_if.wb_val_o); end
    n_checks++; if (tb_if.stall_o !== 1'b1) begin n_fail++; $display("FAIL starve_stall_hold got=%b exp=1", tb_if.stall_o); end
    tick();
    n_checks++; if (tb_if.stall_o !== 1'b0) begin n_fail++; $display("FAIL starve_stall_fall got=%b exp=0", tb_if.stall_o); end
  endtask

  task automatic test_dbg_drop();
    tb_if.pipe_do_wb_i = 1'b1; tb_if.pipe_wb_reg_i = 4'd10; tb_if.pipe_wb_val_i = 32'h1;
    tb_if.dbg_valid_i  = 1'b1; tb_if.dbg_reg_i = 4'd11; tb_if.dbg_val_i = 32'hD0;
    tick(); tick(); tick();
    idle_inputs();
    tick();
    n_checks++; if ({tb_if.do_wb_o, tb_if.wb_src_o} !== {1'b0, 2'd0})
      begin n_fail++; $display("FAIL drop_no_write got=%b/%0d exp=0/0", tb_if.do_wb_o, tb_if.wb_src_o); end
    // Counter must restart from zero: stall after exactly LIMIT+1 more blocked cycles
    tb_if.pipe_do_wb_i = 1'b1;
    tb_if.dbg_valid_i  = 1'b1;
    for (int k = 1; k <= c_LIM + 1; k++) begin
      tick();
      n_checks++; if (tb_if.stall_o !== (k == c_LIM + 1))
        begin n_fail++; $display("FAIL drop_restart_stall[%0d] got=%b exp=%b", k, tb_if.stall_o, (k == c_LIM + 1)); end
    end
    idle_inputs();
    tick(); tick(); tick();
    // rr_ptr untouched: MDU still favoured when both compete
    tb_if.mdu_valid_i = 1'b1;
    tb_if.dbg_valid_i = 1'b1;
    #1;
    n_checks++; if ({tb_if.mdu_ready_o, tb_if.dbg_ready_o} !== 2'b10)
      begin n_fail++; $display("FAIL drop_rr_ptr got=%b%b exp=10", tb_if.mdu_ready_o, tb_if.dbg_ready_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_starve();
    tb_if.pipe_do_wb_i = 1'b1; tb_if.pipe_wb_reg_i = 4'd2; tb_if.pipe_wb_val_i = 32'h2;
    tb_if.mdu_valid_i  = 1'b1; tb_if.mdu_reg_i = 4'd7; tb_if.mdu_val_i = 32'h77;
    for (int k = 1; k <= c_LIM + 1; k++) tick();
    n_checks++; if (tb_if.stall_o !== 1'b1) begin n_fail++; $display("FAIL rs_stall_pre got=%b exp=1", tb_if.stall_o); end
    rst = 1'b1;
    tick();
    n_checks++; if ({tb_if.stall_o, tb_if.do_wb_o} !== 2'b00)
      begin n_fail++; $display("FAIL rs_cleared got=%b%b exp=00", tb_if.stall_o, tb_if.do_wb_o); end
    rst = 1'b0;
    tb_if.pipe_do_wb_i = 1'b0;
    #1;
    n_checks++; if (tb_if.mdu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rs_mdu_ready got=%b exp=1", tb_if.mdu_ready_o); end
    tick();
    tb_if.mdu_valid_i = 1'b0;
    n_checks++; if ({tb_if.do_wb_o, tb_if.wb_reg_o, tb_if.wb_val_o, tb_if.wb_src_o, tb_if.stall_o} !== {1'b1, 4'd7, 32'h77, 2'd2, 1'b0})
      begin n_fail++; $display("FAIL rs_mdu_write got=%b/%0d/%h/%0d stall=%b exp=1/7/77/2 stall=0", tb_if.do_wb_o, tb_if.wb_reg_o, tb_if.wb_val_o, tb_if.wb_src_o, tb_if.stall_o); end
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_pipe_priority();
    test_back_to_back();
    test_starve();
    test_dbg_drop();
    test_reset_starve();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
